// File: rtl/pg_rr_arbiter.sv
// Packet-atomic round-robin merge of matcher lanes onto one packet/meta pair.
// Grant is held from sop to eop; meta and lane id travel with the sop beat.
module pg_rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int META_W = 128,
  parameter int SRC_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NUM_IN*512-1:0]    in_pkt_data,
  input  logic [NUM_IN-1:0]        in_pkt_valid,
  input  logic [NUM_IN-1:0]        in_pkt_sop,
  input  logic [NUM_IN-1:0]        in_pkt_eop,
  input  logic [NUM_IN*6-1:0]      in_pkt_empty,
  output logic [NUM_IN-1:0]        in_pkt_ready,
  input  logic [NUM_IN*META_W-1:0] in_meta_data,
  input  logic [NUM_IN-1:0]        in_meta_valid,
  output logic [NUM_IN-1:0]        in_meta_ready,
  output logic [511:0]             out_pkt_data,
  output logic                     out_pkt_valid,
  output logic                     out_pkt_sop,
  output logic                     out_pkt_eop,
  output logic [5:0]               out_pkt_empty,
  input  logic                     out_pkt_ready,
  output logic [META_W-1:0]        out_meta_data,
  output logic [SRC_W-1:0]         out_meta_src,
  output logic                     out_meta_valid,
  input  logic                     out_meta_ready,
  output logic [31:0]              stats_out_pkt,
  output logic [31:0]              stats_out_meta,
  output logic [31:0]              stats_stall
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  localparam logic [SRC_W:0]   LANES = (SRC_W+1)'(NUM_IN);
  localparam logic [SRC_W-1:0] LAST  = SRC_W'(NUM_IN - 1);

  state_t            state;
  logic [SRC_W-1:0]  gnt;
  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  win;
  logic [SRC_W-1:0]  off;
  logic [SRC_W-1:0]  sel;
  logic [SRC_W-1:0]  nxt;
  logic [SRC_W:0]    sum;
  logic [NUM_IN-1:0] elig;
  logic [2*NUM_IN-1:0] dbl;
  logic              any_elig;
  logic              can_pkt;
  logic              can_meta;
  logic              go_idle;
  logic              rdy_bit;
  logic              acc;

  logic [511:0]      lane_data  [NUM_IN];
  logic [5:0]        lane_empty [NUM_IN];
  logic [META_W-1:0] lane_meta  [NUM_IN];

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    assign lane_data[i]  = in_pkt_data[i*512 +: 512];
    assign lane_empty[i] = in_pkt_empty[i*6 +: 6];
    assign lane_meta[i]  = in_meta_data[i*META_W +: META_W];
  end

  assign can_pkt  = !out_pkt_valid || out_pkt_ready;
  assign can_meta = !out_meta_valid || out_meta_ready;
  assign elig     = in_pkt_valid & in_pkt_sop & in_meta_valid;

  // Rotate so bit 0 is rr_ptr, take the lowest set bit, rotate back.
  always_comb begin
    dbl      = {elig, elig} >> rr_ptr;
    off      = '0;
    any_elig = 1'b0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        off      = k[SRC_W-1:0];
        any_elig = 1'b1;
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= LANES) sum = sum - LANES;
    win = sum[SRC_W-1:0];
  end

  assign sel     = (state == IDLE) ? win : gnt;
  assign nxt     = (sel == LAST) ? '0 : sel + 1'b1;
  assign go_idle = !Rst && (state == IDLE) && any_elig
                   && can_pkt && can_meta;
  assign rdy_bit = Rst ? 1'b0
                 : (state == IDLE) ? go_idle : can_pkt;
  assign acc     = rdy_bit && in_pkt_valid[sel];

  assign in_pkt_ready  = {{(NUM_IN-1){1'b0}}, rdy_bit} << sel;
  assign in_meta_ready = {{(NUM_IN-1){1'b0}}, go_idle} << sel;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state          <= IDLE;
      gnt            <= '0;
      rr_ptr         <= '0;
      out_pkt_data   <= '0;
      out_pkt_valid  <= 1'b0;
      out_pkt_sop    <= 1'b0;
      out_pkt_eop    <= 1'b0;
      out_pkt_empty  <= '0;
      out_meta_data  <= '0;
      out_meta_src   <= '0;
      out_meta_valid <= 1'b0;
      stats_out_pkt  <= '0;
      stats_out_meta <= '0;
      stats_stall    <= '0;
    end else begin
      if (acc) begin
        out_pkt_data  <= lane_data[sel];
        out_pkt_empty <= lane_empty[sel];
        out_pkt_sop   <= in_pkt_sop[sel];
        out_pkt_eop   <= in_pkt_eop[sel];
        out_pkt_valid <= 1'b1;
      end else if (out_pkt_ready) begin
        out_pkt_valid <= 1'b0;
      end

      if (go_idle) begin
        out_meta_data  <= lane_meta[win];
        out_meta_src   <= win;
        out_meta_valid <= 1'b1;
      end else if (out_meta_ready) begin
        out_meta_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (go_idle) begin
            if (in_pkt_eop[win]) begin
              rr_ptr <= nxt;
            end else begin
              state <= LOCKED;
              gnt   <= win;
            end
          end
        end
        LOCKED: begin
          if (acc && in_pkt_eop[gnt]) begin
            state  <= IDLE;
            rr_ptr <= nxt;
          end
        end
        default: state <= IDLE;
      endcase

      if (out_pkt_valid && out_pkt_ready && out_pkt_eop)
        stats_out_pkt <= stats_out_pkt + 32'd1;
      if (out_meta_valid && out_meta_ready)
        stats_out_meta <= stats_out_meta + 32'd1;
      if (out_pkt_valid && !out_pkt_ready)
        stats_stall <= stats_stall + 32'd1;
    end
  end

endmodule

// File: tb/tb_pg_rr_arbiter.sv
// Directed table-driven bench for pg_rr_arbiter.
// Each record holds one cycle of lane stimulus and the expected result.
module tb_pg_rr_arbiter;

  localparam int N  = 4;
  localparam int MW = 128;

  logic            Clk = 1'b0;
  logic            Rst;
  logic [N*512-1:0] in_pkt_data;
  logic [N-1:0]    in_pkt_valid;
  logic [N-1:0]    in_pkt_sop;
  logic [N-1:0]    in_pkt_eop;
  logic [N*6-1:0]  in_pkt_empty;
  logic [N-1:0]    in_pkt_ready;
  logic [N*MW-1:0] in_meta_data;
  logic [N-1:0]    in_meta_valid;
  logic [N-1:0]    in_meta_ready;
  logic [511:0]    out_pkt_data;
  logic            out_pkt_valid;
  logic            out_pkt_sop;
  logic            out_pkt_eop;
  logic [5:0]      out_pkt_empty;
  logic            out_pkt_ready;
  logic [MW-1:0]   out_meta_data;
  logic [1:0]      out_meta_src;
  logic            out_meta_valid;
  logic            out_meta_ready;
  logic [31:0]     stats_out_pkt;
  logic [31:0]     stats_out_meta;
  logic [31:0]     stats_stall;

  pg_rr_arbiter #(.NUM_IN(N), .META_W(MW)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_pkt_data(in_pkt_data), .in_pkt_valid(in_pkt_valid),
    .in_pkt_sop(in_pkt_sop), .in_pkt_eop(in_pkt_eop),
    .in_pkt_empty(in_pkt_empty), .in_pkt_ready(in_pkt_ready),
    .in_meta_data(in_meta_data), .in_meta_valid(in_meta_valid),
    .in_meta_ready(in_meta_ready),
    .out_pkt_data(out_pkt_data), .out_pkt_valid(out_pkt_valid),
    .out_pkt_sop(out_pkt_sop), .out_pkt_eop(out_pkt_eop),
    .out_pkt_empty(out_pkt_empty), .out_pkt_ready(out_pkt_ready),
    .out_meta_data(out_meta_data), .out_meta_src(out_meta_src),
    .out_meta_valid(out_meta_valid), .out_meta_ready(out_meta_ready),
    .stats_out_pkt(stats_out_pkt), .stats_out_meta(stats_out_meta),
    .stats_stall(stats_stall)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit [3:0] v, s, e, m;
    bit       ordy, mrdy;
    bit [7:0] bt;
    bit [3:0] xr;
    bit       xv, xs, xe;
    bit [1:0] xl;
    bit [7:0] xb;
    bit       xm;
    bit [1:0] xsr;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   vn = 0;

  function automatic vec_t mk(int v, int s, int e, int m, int ordy,
                              int mrdy, int bt, int xr, int xv, int xs,
                              int xe, int xl, int xb, int xm, int xsr);
    vec_t r;
    r.v = 4'(v); r.s = 4'(s); r.e = 4'(e); r.m = 4'(m);
    r.ordy = 1'(ordy); r.mrdy = 1'(mrdy); r.bt = 8'(bt);
    r.xr = 4'(xr); r.xv = 1'(xv); r.xs = 1'(xs); r.xe = 1'(xe);
    r.xl = 2'(xl); r.xb = 8'(xb); r.xm = 1'(xm); r.xsr = 2'(xsr);
    return r;
  endfunction

  task automatic add(int v, int s, int e, int m, int ordy, int mrdy,
                     int bt, int xr, int xv, int xs, int xe, int xl,
                     int xb, int xm, int xsr);
    tbl.push_back(mk(v, s, e, m, ordy, mrdy, bt, xr, xv, xs, xe,
                     xl, xb, xm, xsr));
  endtask

  task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    in_pkt_valid   = t.v;
    in_pkt_sop     = t.s;
    in_pkt_eop     = t.e;
    in_meta_valid  = t.m;
    out_pkt_ready  = t.ordy;
    out_meta_ready = t.mrdy;
    for (int i = 0; i < N; i++) begin
      in_pkt_data[i*512 +: 512] = {496'b0, 8'(i), t.bt};
      in_pkt_empty[i*6 +: 6]    = 6'(i + 1);
      in_meta_data[i*MW +: MW]  = {120'b0, 8'hA0 | 8'(i)};
    end
  endtask

  task automatic chk_out(vec_t t, string tag);
    if (t.xv)
      check({tag, "_pkt"},
            {out_pkt_valid, out_pkt_sop, out_pkt_eop, out_pkt_empty,
             out_pkt_data[15:0], |out_pkt_data[511:16]},
            {1'b1, t.xs, t.xe, 6'(t.xl) + 6'd1, 6'b0, t.xl, t.xb, 1'b0});
    else
      check({tag, "_pktv"}, 128'(out_pkt_valid), 128'd0);
    if (t.xm)
      check({tag, "_meta"},
            {out_meta_valid, out_meta_src, out_meta_data[7:0],
             |out_meta_data[MW-1:8]},
            {1'b1, t.xsr, 8'hA0 | {6'b0, t.xsr}, 1'b0});
    else
      check({tag, "_metav"}, 128'(out_meta_valid), 128'd0);
  endtask

  // Called at a falling edge; leaves at a falling edge.
  task automatic run_tbl();
    vec_t  t;
    string tag;
    for (int i = 0; i < tbl.size(); i++) begin
      t   = tbl[i];
      tag = $sformatf("v%0d", vn);
      vn++;
      drive(t);
      #1;
      check({tag, "_rdy"}, {in_pkt_ready, in_meta_ready},
            {t.xr, t.xr & t.v & t.s & t.m});
      @(negedge Clk);
      chk_out(t, tag);
    end
    tbl.delete();
  endtask

  task automatic chk_zero(string tag);
    check({tag, "_outs"},
          {out_pkt_valid, out_meta_valid, out_pkt_sop, out_pkt_eop,
           out_pkt_empty, |out_pkt_data, |out_meta_data, out_meta_src},
          128'd0);
    check({tag, "_stats"}, {stats_out_pkt, stats_out_meta, stats_stall},
          128'd0);
  endtask

  task automatic do_reset(string tag);
    drive(mk(1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    Rst = 1'b1;
    @(negedge Clk);
    check({tag, "_rdy"}, {in_pkt_ready, in_meta_ready}, 128'd0);
    @(negedge Clk);
    chk_zero(tag);
    Rst = 1'b0;
    drive(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    Rst = 1'b1;
    drive(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge Clk);
    do_reset("rst0");

    // Lane 0 alone, three beats.
    add(1, 1, 0, 1, 1, 1, 1,  1, 1, 1, 0, 0, 1,  1, 0);
    add(1, 0, 0, 0, 1, 1, 2,  1, 1, 0, 0, 0, 2,  0, 0);
    add(1, 0, 1, 0, 1, 1, 3,  1, 1, 0, 1, 0, 3,  0, 0);
    add(0, 0, 0, 0, 1, 1, 4,  0, 0, 0, 0, 0, 0,  0, 0);
    run_tbl();
    check("t1_stats", {stats_out_pkt, stats_out_meta, stats_stall},
          {32'd1, 32'd1, 32'd0});

    do_reset("rst1");
    // All lanes at once, then pointer-wrap proof with lanes 0 and 3.
    add(15, 15, 15, 15, 1, 1, 10, 1, 1, 1, 1, 0, 10, 1, 0);
    add(14, 15, 15, 14, 1, 1, 11, 2, 1, 1, 1, 1, 11, 1, 1);
    add(12, 15, 15, 12, 1, 1, 12, 4, 1, 1, 1, 2, 12, 1, 2);
    add(8,  15, 15, 8,  1, 1, 13, 8, 1, 1, 1, 3, 13, 1, 3);
    add(0,  0,  0,  0,  1, 1, 14, 0, 0, 0, 0, 0, 0,  0, 0);
    add(9,  9,  9,  9,  1, 1, 15, 1, 1, 1, 1, 0, 15, 1, 0);
    add(8,  9,  9,  8,  1, 1, 16, 8, 1, 1, 1, 3, 16, 1, 3);
    add(0,  0,  0,  0,  1, 1, 17, 0, 0, 0, 0, 0, 0,  0, 0);
    run_tbl();

    // Lane 1 locked with a bubble; lane 2 waits for its eop.
    add(2, 2, 0, 2, 1, 1, 20, 2, 1, 1, 0, 1, 20, 1, 1);
    add(6, 4, 0, 4, 1, 1, 21, 2, 1, 0, 0, 1, 21, 0, 0);
    add(4, 4, 0, 4, 1, 1, 22, 2, 0, 0, 0, 0, 0,  0, 0);
    add(6, 4, 0, 4, 1, 1, 22, 2, 1, 0, 0, 1, 22, 0, 0);
    add(6, 4, 2, 4, 1, 1, 23, 2, 1, 0, 1, 1, 23, 0, 0);
    add(4, 4, 4, 4, 1, 1, 24, 4, 1, 1, 1, 2, 24, 1, 2);
    add(0, 0, 0, 0, 1, 1, 25, 0, 0, 0, 0, 0, 0,  0, 0);
    run_tbl();

    // Five-cycle output backpressure mid-packet on lane 3.
    add(8, 8, 0, 8, 1, 1, 30, 8, 1, 1, 0, 3, 30, 1, 3);
    for (int i = 0; i < 5; i++)
      add(8, 0, 0, 0, 0, 1, 31, 0, 1, 1, 0, 3, 30, 0, 0);
    add(8, 0, 0, 0, 1, 1, 31, 8, 1, 0, 0, 3, 31, 0, 0);
    add(8, 0, 8, 0, 1, 1, 32, 8, 1, 0, 1, 3, 32, 0, 0);
    add(0, 0, 0, 0, 1, 1, 33, 0, 0, 0, 0, 0, 0,  0, 0);
    run_tbl();
    check("t4_stats", {stats_out_pkt, stats_out_meta, stats_stall},
          {32'd9, 32'd9, 32'd5});

    // Lane 3 lacks meta: skipped despite pointer, granted once meta shows.
    add(1, 1, 1, 1, 1, 1, 40, 1, 1, 1, 1, 0, 40, 1, 0);
    add(9, 9, 9, 1, 1, 1, 41, 1, 1, 1, 1, 0, 41, 1, 0);
    add(8, 8, 8, 8, 1, 1, 42, 8, 1, 1, 1, 3, 42, 1, 3);
    add(0, 0, 0, 0, 1, 1, 43, 0, 0, 0, 0, 0, 0,  0, 0);
    // Full meta register blocks the next sop.
    add(1, 1, 1, 1, 1, 0, 50, 1, 1, 1, 1, 0, 50, 1, 0);
    add(2, 2, 2, 2, 1, 0, 51, 0, 0, 0, 0, 0, 0,  1, 0);
    add(2, 2, 2, 2, 1, 1, 51, 2, 1, 1, 1, 1, 51, 1, 1);
    add(0, 0, 0, 0, 1, 1, 52, 0, 0, 0, 0, 0, 0,  0, 0);
    run_tbl();

    // Reset while locked on lane 2.
    drive(mk(4, 4, 0, 4, 1, 1, 60, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge Clk);
    check("t6_lock", {out_pkt_valid, out_pkt_sop, out_meta_src},
          {1'b1, 1'b1, 2'd2});
    drive(mk(4, 0, 0, 0, 1, 1, 61, 0, 0, 0, 0, 0, 0, 0, 0));
    Rst = 1'b1;
    #1;
    check("t6_rdy", {in_pkt_ready, in_meta_ready}, 128'd0);
    @(negedge Clk);
    chk_zero("t6");
    Rst = 1'b0;
    add(4, 0, 0, 0, 1, 1, 62, 0, 0, 0, 0, 0, 0,  0, 0);
    add(7, 3, 3, 3, 1, 1, 63, 1, 1, 1, 1, 0, 63, 1, 0);
    add(6, 2, 2, 2, 1, 1, 64, 2, 1, 1, 1, 1, 64, 1, 1);
    add(0, 0, 0, 0, 1, 1, 65, 0, 0, 0, 0, 0, 0,  0, 0);
    run_tbl();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
